// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and default constants for the mem_loader slice.
//
// Contents:
//   ML_DEPTH, ML_WIDTH      memory geometry (32 words x 8 bits)
//   ML_START_ADDR           first address written by the incoming stream
//   ML_LOAD_END             last address the stream may write
//   ML_FILL_VALUE           pad byte for the tail region
//   mem_loader_state_t      loader FSM states
//
// Build option: MEM_LOADER_FILL_EN adds the FILL state, which pads the tail region.

package mem_loader_pkg;

    localparam int              ML_DEPTH      = 32;
    localparam int              ML_WIDTH      = 8;
    localparam int              ML_START_ADDR = 5;
    localparam int              ML_LOAD_END   = 19;
    localparam logic [7:0]      ML_FILL_VALUE = 8'hEF;

`ifdef MEM_LOADER_FILL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } mem_loader_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd3
    } mem_loader_state_t;
`endif

endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte stream (valid/ready) and read port between mem_loader and its neighbours.
//
// Signals:
//   in_valid  master->slave  stream byte valid
//   in_data   master->slave  stream byte
//   in_last   master->slave  final byte of the stream
//   in_ready  slave->master  loader accepts a byte this cycle
//   rd_addr   master->slave  read address
//   rd_data   slave->master  registered read data (one cycle after rd_addr)

interface mem_loader_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 5
);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    // Upstream producer / downstream reader side.
    modport master (
        output in_valid, in_data, in_last, rd_addr,
        input  in_ready, rd_data
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data, in_last, rd_addr,
        output in_ready, rd_data
    );

endinterface

// File: rtl/mem_loader_ram.sv
// mem_loader_ram: DEPTH x WIDTH storage with one write port and one registered read port.
//
// Ports:
//   clk, rst_n  clock; asynchronous active-low clear of every word and of rdata
//   we, waddr, wdata   write port, written at the rising edge
//   raddr, rdata       read port, rdata = mem[raddr] one cycle later
// A read and a write to the same address in the same cycle return the old word.

module mem_loader_ram #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is built from resettable flops rather than a RAM macro because
    // the memory must read back as all-zero after reset; a macro cannot be cleared this way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            // Sampled before this edge's write lands, so a same-address
            // read/write returns the previous contents.
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: fills a DEPTH x WIDTH memory from a byte stream, optionally pads the tail,
// then serves reads.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset (returns to IDLE, clears memory)
//   start        one-cycle request to begin a load (honoured in IDLE and DONE only)
//   bus          mem_loader_if.slave: stream in_valid/in_data/in_last/in_ready,
//                read port rd_addr/rd_data
//   busy         high while loading or filling
//   done         high once the load (and fill) has completed, until the next start
//   load_count   bytes accepted in the current or last load
//
// Build option: MEM_LOADER_FILL_EN. When defined, LOAD is followed by FILL, which writes
// FILL_VALUE to LOAD_END+1 .. DEPTH-1. When undefined, LOAD goes straight to DONE and
// the tail region keeps its previous contents.

module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int DEPTH      = ML_DEPTH,
    parameter int WIDTH      = ML_WIDTH,
    parameter int START_ADDR = ML_START_ADDR,
    parameter int LOAD_END   = ML_LOAD_END
`ifdef MEM_LOADER_FILL_EN
    ,
    parameter logic [WIDTH-1:0] FILL_VALUE = ML_FILL_VALUE
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    mem_loader_if.slave                bus,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] load_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    mem_loader_state_t state, state_nxt;
    logic [AW-1:0]     wr_addr, wr_addr_nxt;
    logic [CW-1:0]     count_nxt;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;
    logic              accept;

    // Status outputs decode straight from the state register; IDLE gives the all-zero reset values.
    assign bus.in_ready = (state == ST_LOAD);
    assign done         = (state == ST_DONE);
`ifdef MEM_LOADER_FILL_EN
    assign busy         = (state == ST_LOAD) || (state == ST_FILL);
`else
    assign busy         = (state == ST_LOAD);
`endif

    assign accept = bus.in_valid & bus.in_ready;

    // NOTE: state is written with non-blocking assignments so every flop samples the
    // pre-edge values; blocking assignments here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_addr    <= '0;
            load_count <= '0;
        end else begin
            state      <= state_nxt;
            wr_addr    <= wr_addr_nxt;
            load_count <= count_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        count_nxt   = load_count;
        wr_en       = 1'b0;
        wr_data     = bus.in_data;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt   = ST_LOAD;
                    wr_addr_nxt = AW'(START_ADDR);
                    count_nxt   = '0;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    wr_en       = 1'b1;
                    wr_addr_nxt = wr_addr + AW'(1);
                    count_nxt   = load_count + CW'(1);
                    // Either the producer ends the stream or the load window is full.
                    if (bus.in_last || (wr_addr == AW'(LOAD_END))) begin
`ifdef MEM_LOADER_FILL_EN
                        state_nxt   = ST_FILL;
                        wr_addr_nxt = AW'(LOAD_END + 1);
`else
                        state_nxt   = ST_DONE;
`endif
                    end
                end
            end

`ifdef MEM_LOADER_FILL_EN
            ST_FILL: begin
                wr_en       = 1'b1;
                wr_data     = FILL_VALUE;
                wr_addr_nxt = wr_addr + AW'(1);
                if (wr_addr == AW'(DEPTH - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
`endif

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    mem_loader_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: self-checking bench for mem_loader.
// Expected memory contents come from a behavioural image of the memory: a load of
// n bytes places them at START_ADDR.., and the tail is padded when MEM_LOADER_FILL_EN
// is defined. Latency expectations come from the size of the tail region.

module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int AW   = $clog2(ML_DEPTH);
    localparam int CW   = $clog2(ML_DEPTH + 1);
    localparam int MAXN = ML_LOAD_END - ML_START_ADDR + 1;
`ifdef MEM_LOADER_FILL_EN
    localparam bit FILL_ON  = 1'b1;
    localparam int FILL_LAT = ML_DEPTH - 1 - ML_LOAD_END;
`else
    localparam bit FILL_ON  = 1'b0;
    localparam int FILL_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] load_count;

    mem_loader_if #(.WIDTH(ML_WIDTH), .AW(AW)) bus ();

    mem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [ML_WIDTH-1:0] exp_mem  [ML_DEPTH];
    logic [ML_WIDTH-1:0] stream_b [MAXN];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < ML_DEPTH; a++) begin
            bus.rd_addr = AW'(a);
            step();
            check($sformatf("%s[%0d]", tag, a), 32'(bus.rd_data), 32'(exp_mem[a]));
        end
    endtask

    // stall_mode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random.
    task automatic run_load(input int n, input bit use_last, input int stall_mode,
                            input bit pulse_start, input bit rdw);
        int idx;
        int cyc;
        int lat;
        bit v;
        bit rdw_now;

        start = 1'b1;
        step();
        start = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        check("ready_t1", 32'(bus.in_ready), 32'd1);

        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            case (stall_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = stream_b[idx];
            bus.in_last  = use_last && (idx == n - 1);
            start        = pulse_start && !v;
            rdw_now      = rdw && v && (idx == 1);
            if (rdw_now) bus.rd_addr = AW'(ML_START_ADDR + 1);
            check("ready_in_load", 32'(bus.in_ready), 32'd1);
            step();
            if (rdw_now) begin
                check("rd_old_data", 32'(bus.rd_data), 32'(exp_mem[ML_START_ADDR + 1]));
            end
            if (v) idx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        start        = 1'b0;
        check("stream_budget", idx, n);

        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            check("busy_fill", 32'(busy), 32'd1);
            start = pulse_start && (lat == 3);
            step();
            start = 1'b0;
            lat++;
        end
        check("done_latency", lat, FILL_LAT);

        for (int i = 0; i < n; i++) exp_mem[ML_START_ADDR + i] = stream_b[i];
        if (FILL_ON) begin
            for (int a = ML_LOAD_END + 1; a < ML_DEPTH; a++) exp_mem[a] = ML_FILL_VALUE;
        end

        check("load_count", 32'(load_count), n);
        check("done_busy", 32'(busy), 32'd0);
        check("done_ready", 32'(bus.in_ready), 32'd0);
        read_all("mem");
        check("done_held", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit last;

        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.rd_addr  = '0;
        for (int a = 0; a < ML_DEPTH; a++) exp_mem[a] = '0;

        // Reset state.
        step();
        step();
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        rst_n = 1'b1;
        step();
        read_all("rst_mem");

        // Full 15-byte stream, no stalls; exit on reaching LOAD_END (in_last never set).
        for (int i = 0; i < MAXN; i++) stream_b[i] = ML_WIDTH'(i + 1);
        run_load(MAXN, 1'b0, 0, 1'b0, 1'b0);

        // Short stream terminated by in_last; also a same-address read/write on addr 6.
        stream_b[0] = 8'hA0;
        stream_b[1] = 8'hA1;
        stream_b[2] = 8'hA2;
        run_load(3, 1'b1, 0, 1'b0, 1'b1);

        // Full stream with valid every other cycle; start pulsed during stalls and FILL.
        for (int i = 0; i < MAXN; i++) stream_b[i] = ML_WIDTH'(i + 1);
        run_load(MAXN, 1'b0, 1, 1'b1, 1'b0);

        // Randomised loads.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, MAXN);
            last = (n < MAXN) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < MAXN; i++) stream_b[i] = ML_WIDTH'($urandom);
            run_load(n, last, 2, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset after four accepts.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ML_WIDTH'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_count", 32'(load_count), 32'd4);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_count", 32'(load_count), 32'd0);
        check("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
        step();
        rst_n = 1'b1;
        for (int a = 0; a < ML_DEPTH; a++) exp_mem[a] = '0;
        step();
        check("post_rst_count", 32'(load_count), 32'd0);
        read_all("post_rst_mem");

        // Recovery after reset.
        n = $urandom_range(1, MAXN);
        for (int i = 0; i < MAXN; i++) stream_b[i] = ML_WIDTH'($urandom);
        run_load(n, 1'b1, 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
